// File: rtl/lsu_ctrl.sv
// Load/store controller: byte-addressed RISC-V loads/stores onto a word-addressed data_mem port.
// Define LSU_MISALIGNED_EN to split misaligned halfword/word accesses into byte/word beats.
module lsu_ctrl #(
   parameter  int DEPTH = 128,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [31:0]   resp_rdata,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_din,
   output logic          mem_we,
   output logic [2:0]    mem_wr_strb
);

`ifdef LSU_MISALIGNED_EN
   localparam int CW = 2;
`else
   localparam int CW = 1;
`endif

   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
   localparam logic [2:0]  STRB_WORD = 3'b000;
   localparam logic [2:0]  STRB_HLO  = 3'b001;
   localparam logic [2:0]  STRB_HHI  = 3'b011;
   localparam logic [2:0]  STRB_NOP  = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     word0_q, word0_d;
   logic            mis_q, mis_d;
   logic [CW-1:0]   beat_q, beat_d;
   logic [CW-1:0]   last_q, last_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic            resp_err_q, resp_err_d;
   logic [31:0]     resp_rdata_q, resp_rdata_d;
   logic [AW-1:0]   mem_rd_addr_q, mem_rd_addr_d;
   logic [AW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
   logic [31:0]     mem_wr_din_q, mem_wr_din_d;
   logic            mem_we_q, mem_we_d;
   logic [2:0]      mem_wr_strb_q, mem_wr_strb_d;

   // request decode
   logic            hs;
   logic [1:0]      req_size_m1;
   logic [29:0]     req_end_w;
   logic            req_mis;
   logic            req_f3_bad;
   logic            req_range_bad;
   logic            req_err;
   logic [CW-1:0]   req_last;

   always_comb begin
      hs = req_valid && req_ready_q;
      unique case (req_funct3[1:0])
         2'b00:   req_size_m1 = 2'd0;
         2'b01:   req_size_m1 = 2'd1;
         default: req_size_m1 = 2'd3;
      endcase
      req_end_w = 30'((req_addr + {30'b0, req_size_m1}) >> 2);
      req_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  (req_funct3[1] && (req_addr[1:0] != 2'b00));
      if (req_we) req_f3_bad = req_funct3[2];
      else        req_f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      req_range_bad = ({2'b00, req_addr[31:2]} >= DEPTH_W) || ({2'b00, req_end_w} >= DEPTH_W);
`ifdef LSU_MISALIGNED_EN
      req_err  = req_f3_bad || req_range_bad;
      req_last = !req_mis ? 2'd0 : (req_we ? req_size_m1 : 2'd1);
`else
      req_err  = req_f3_bad || req_range_bad || req_mis;
      req_last = 1'b0;
`endif
   end

   // Memory port values for the beat about to start: beat 0 from the request, later beats from held state.
   logic            drv_en;
   logic            src_we;
   logic [1:0]      src_size;
   logic [AW+1:0]   src_addr;
   logic [31:0]     src_wdata;
   logic            src_mis;
   logic [CW-1:0]   src_beat;
   logic [AW+1:0]   drv_byte_addr;
   logic [AW-1:0]   drv_rd_addr;
   logic [AW-1:0]   drv_wr_addr;
   logic [31:0]     drv_din;
   logic [2:0]      drv_strb;

   always_comb begin
      if (state_q == S_IDLE) begin
         src_we    = req_we;
         src_size  = req_funct3[1:0];
         src_addr  = req_addr[AW+1:0];
         src_wdata = req_wdata;
         src_mis   = req_mis;
         src_beat  = '0;
         drv_en    = hs && !req_err;
      end else begin
         src_we    = we_q;
         src_size  = f3_q[1:0];
         src_addr  = addr_q;
         src_wdata = wdata_q;
         src_mis   = mis_q;
         src_beat  = beat_q + 1'b1;
         drv_en    = (state_q == S_BEAT) && (beat_q != last_q);
      end
      drv_byte_addr = src_addr + {{(AW+2-CW){1'b0}}, src_beat};
      drv_rd_addr   = src_addr[AW+1:2] + {{(AW-CW){1'b0}}, src_beat};
      drv_wr_addr   = drv_byte_addr[AW+1:2];
      drv_strb      = STRB_NOP;
      drv_din       = '0;
      if (src_we) begin
         if (src_mis) begin
            drv_strb = {1'b1, drv_byte_addr[1:0]};
            drv_din  = {24'b0, 8'(src_wdata >> {src_beat, 3'b000})};
         end else begin
            unique case (src_size)
               2'b00: begin
                  drv_strb = {1'b1, src_addr[1:0]};
                  drv_din  = {24'b0, src_wdata[7:0]};
               end
               2'b01: begin
                  drv_strb = src_addr[1] ? STRB_HHI : STRB_HLO;
                  drv_din  = {16'b0, src_wdata[15:0]};
               end
               default: begin
                  drv_strb = STRB_WORD;
                  drv_din  = src_wdata;
               end
            endcase
         end
      end
   end

   // Load result: a split load combines the captured lower word with the word read in the last beat.
   logic [63:0] ld_raw;
   logic [31:0] ld_word;
   logic [31:0] ld_ext;

   always_comb begin
      ld_raw  = (beat_q == '0) ? {32'b0, mem_rd_data} : {mem_rd_data, word0_q};
      ld_word = 32'(ld_raw >> {addr_q[1:0], 3'b000});
      unique case (f3_q)
         3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
         3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
         3'b100:  ld_ext = {24'b0, ld_word[7:0]};
         3'b101:  ld_ext = {16'b0, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      f3_d          = f3_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      word0_d       = word0_q;
      mis_d         = mis_q;
      beat_d        = beat_q;
      last_d        = last_q;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = '0;
      mem_we_d      = 1'b0;
      mem_wr_strb_d = STRB_NOP;
      mem_rd_addr_d = '0;
      mem_wr_addr_d = '0;
      mem_wr_din_d  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (hs) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               mis_d   = req_mis && !req_err;
               beat_d  = '0;
               last_d  = req_last;
               if (req_err) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d = S_BEAT;
               end
            end
         end
         S_BEAT: begin
            if (beat_q == '0) word0_d = mem_rd_data;
            if (beat_q == last_q) begin
               state_d      = S_DONE;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'b0 : ld_ext;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (drv_en) begin
         mem_we_d      = src_we;
         mem_wr_strb_d = drv_strb;
         mem_rd_addr_d = drv_rd_addr;
         mem_wr_addr_d = drv_wr_addr;
         mem_wr_din_d  = drv_din;
      end
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         we_q          <= 1'b0;
         f3_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         word0_q       <= '0;
         mis_q         <= 1'b0;
         beat_q        <= '0;
         last_q        <= '0;
         req_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= '0;
         mem_we_q      <= 1'b0;
         mem_wr_strb_q <= STRB_NOP;
         mem_rd_addr_q <= '0;
         mem_wr_addr_q <= '0;
         mem_wr_din_q  <= '0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         f3_q          <= f3_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         word0_q       <= word0_d;
         mis_q         <= mis_d;
         beat_q        <= beat_d;
         last_q        <= last_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_err_q    <= resp_err_d;
         resp_rdata_q  <= resp_rdata_d;
         mem_we_q      <= mem_we_d;
         mem_wr_strb_q <= mem_wr_strb_d;
         mem_rd_addr_q <= mem_rd_addr_d;
         mem_wr_addr_q <= mem_wr_addr_d;
         mem_wr_din_q  <= mem_wr_din_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign resp_rdata  = resp_rdata_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign mem_wr_addr = mem_wr_addr_q;
   assign mem_wr_din  = mem_wr_din_q;
   assign mem_wr_strb = mem_wr_strb_q;
   // A reset arriving mid-beat must suppress the write committing at that same edge.
   assign mem_we      = mem_we_q && rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-level reference memory, response and write-beat scoreboards.
// Build with LSU_MISALIGNED_EN defined to exercise split accesses.
module tb_lsu_ctrl;
   localparam int DEPTH = 128;
   localparam int AW    = $clog2(DEPTH);
`ifdef LSU_MISALIGNED_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_rd_addr;
   logic [31:0]   mem_rd_data;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_din;
   logic          mem_we;
   logic [2:0]    mem_wr_strb;

   lsu_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
      .mem_we(mem_we), .mem_wr_strb(mem_wr_strb)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // data_mem model: asynchronous read, strobe-decoded write
   logic [31:0] dmem [DEPTH];
   assign mem_rd_data = dmem[mem_rd_addr];
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_wr_strb[2])              dmem[mem_wr_addr][8*mem_wr_strb[1:0] +: 8] <= mem_wr_din[7:0];
         else if (mem_wr_strb == 3'b000)  dmem[mem_wr_addr]        <= mem_wr_din;
         else if (mem_wr_strb == 3'b001)  dmem[mem_wr_addr][15:0]  <= mem_wr_din[15:0];
         else if (mem_wr_strb == 3'b011)  dmem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
      end
   end

   logic [7:0]  ref_mem [4*DEPTH];
   logic [64:0] exp_q[$];        // {err, rdata, response cycle}
   logic [41:0] exp_beat_q[$];   // {wr_addr, strb, din}

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard
   logic [64:0] mon_e;
   logic [41:0] mon_b;
   always @(negedge clk) begin
      if (rst) begin
         if (resp_valid) begin
            if (exp_q.size() == 0) check("resp_unexpected", resp_valid, 64'd0);
            else begin
               mon_e = exp_q.pop_front();
               check("resp_err", resp_err, mon_e[64]);
               check("resp_rdata", resp_rdata, mon_e[63:32]);
               check("resp_cycle", cyc, mon_e[31:0]);
            end
         end
         if (mem_we) begin
            if (exp_beat_q.size() == 0) check("beat_unexpected", mem_we, 64'd0);
            else begin
               mon_b = exp_beat_q.pop_front();
               check("beat_addr", mem_wr_addr, mon_b[41:35]);
               check("beat_strb", mem_wr_strb, mon_b[34:32]);
               check("beat_din", mem_wr_din, mon_b[31:0]);
            end
         end
      end
   end

   task automatic wait_ready();
      int waited;
      waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", req_ready, 64'd1);
   endtask

   // driver: computes expectations from the reference memory, then issues one request
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
      int sz, lat;
      bit mis, err;
      logic [31:0] ld, ba, dn;
      logic [2:0] st;
      wait_ready();
      if (!req_ready) return;
      sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
      err = we ? f3[2] : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      if ((addr >> 2) >= DEPTH || ((addr + sz - 1) >> 2) >= DEPTH) err = 1'b1;
      if (mis && !MIS_EN) err = 1'b1;
      lat = err ? 1 : (!mis ? 2 : (we ? sz + 1 : 3));
      ld  = '0;
      if (!err && we) begin
         if (!mis) begin
            if (sz == 4)      begin st = 3'b000; dn = wdata; end
            else if (sz == 2) begin st = addr[1] ? 3'b011 : 3'b001; dn = {16'b0, wdata[15:0]}; end
            else              begin st = {1'b1, addr[1:0]}; dn = {24'b0, wdata[7:0]}; end
            exp_beat_q.push_back({addr[AW+1:2], st, dn});
         end else begin
            for (int i = 0; i < sz; i++) begin
               ba = addr + i;
               exp_beat_q.push_back({ba[AW+1:2], 1'b1, ba[1:0], 24'b0, wdata[8*i +: 8]});
            end
         end
         for (int i = 0; i < sz; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else if (!err) begin
         for (int i = 0; i < sz; i++) ld[8*i +: 8] = ref_mem[addr + i];
         if (f3 == 3'b000) ld = {{24{ld[7]}}, ld[7:0]};
         if (f3 == 3'b001) ld = {{16{ld[15]}}, ld[15:0]};
      end
      exp_q.push_back({err, ld, 32'(cyc + lat)});
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk);
      check("ready_busy", req_ready, 64'd0);
   endtask

   int idx;
   logic [2:0] rf3;
   logic rwe;
   logic [31:0] raddr;
   int drain;

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 64'd0);
      check("rst_resp_valid", resp_valid, 64'd0);
      check("rst_resp_err", resp_err, 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_mem_we", mem_we, 64'd0);
      check("rst_mem_wr_strb", mem_wr_strb, 64'd2);
      check("rst_mem_rd_addr", mem_rd_addr, 64'd0);
      check("rst_mem_wr_addr", mem_wr_addr, 64'd0);
      check("rst_mem_wr_din", mem_wr_din, 64'd0);
      rst = 1'b1;

      // directed cases
      send(1, 3'b010, 32'h8, 32'hDEADBEEF);
      send(0, 3'b010, 32'h8, 32'h0);
      send(1, 3'b000, 32'h5, 32'h00000080);
      send(0, 3'b000, 32'h5, 32'h0);
      send(0, 3'b100, 32'h5, 32'h0);
      send(1, 3'b001, 32'h2, 32'h1234ABCD);
      send(0, 3'b001, 32'h2, 32'h0);
      send(0, 3'b101, 32'h2, 32'h0);
      send(1, 3'b001, 32'h0, 32'h00007FFF);
      send(0, 3'b001, 32'h0, 32'h0);
      send(0, 3'b010, 32'h0, 32'h0);
      send(1, 3'b010, 32'h6, 32'h11223344);
      send(0, 3'b010, 32'h6, 32'h0);
      send(1, 3'b001, 32'h3, 32'h0000BEEF);
      send(0, 3'b001, 32'h3, 32'h0);
      send(0, 3'b101, 32'h3, 32'h0);
      send(0, 3'b011, 32'h8, 32'h0);
      send(1, 3'b010, 32'(4*DEPTH), 32'hCAFEF00D);
      send(1, 3'b100, 32'h8, 32'h1);
      send(0, 3'b110, 32'h8, 32'h0);
      send(1, 3'b010, 32'(4*DEPTH-4), 32'hA5A55A5A);
      send(0, 3'b010, 32'(4*DEPTH-4), 32'h0);
      send(0, 3'b001, 32'(4*DEPTH-1), 32'h0);
      send(0, 3'b010, 32'(4*DEPTH-2), 32'h0);
      send(1, 3'b000, 32'(4*DEPTH-1), 32'h00000077);
      send(0, 3'b100, 32'(4*DEPTH-1), 32'h0);

      // random mix over a small window plus the top boundary
      for (int k = 0; k < 40; k++) begin
         rwe = 1'($urandom_range(0, 1));
         if (rwe) rf3 = 3'($urandom_range(0, 2));
         else begin
            idx = $urandom_range(0, 4);
            rf3 = (idx < 3) ? 3'(idx) : 3'(idx + 1);
         end
         raddr = (k % 8 == 7) ? $urandom_range(4*DEPTH-3, 4*DEPTH+3) : $urandom_range(0, 63);
         send(rwe, rf3, raddr, $urandom);
      end

      // reset in the middle of a store: no response, no write past the abort
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'hA1B2C3D4;
`ifdef LSU_MISALIGNED_EN
      req_addr = 32'h11;
      exp_beat_q.push_back({7'd4, 3'b101, 32'h000000D4});
      ref_mem[32'h11] = 8'hD4;
`else
      req_addr = 32'h10;
`endif
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`ifdef LSU_MISALIGNED_EN
      @(posedge clk);
      #1;
`endif
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_resp_valid", resp_valid, 64'd0);
      check("abort_req_ready", req_ready, 64'd0);
      check("abort_mem_we", mem_we, 64'd0);
      check("abort_mem_wr_strb", mem_wr_strb, 64'd2);
      rst = 1'b1;
      send(0, 3'b010, 32'h10, 32'h0);
      send(0, 3'b010, 32'h14, 32'h0);
      send(0, 3'b100, 32'h12, 32'h0);

      drain = 0;
      while ((exp_q.size() != 0 || exp_beat_q.size() != 0) && drain < 20) begin
         @(negedge clk);
         drain++;
      end
      check("drain_resp", exp_q.size(), 64'd0);
      check("drain_beat", exp_beat_q.size(), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the core's execute stage and `data_mem`. It accepts one byte-addressed RISC-V load or store per handshake and translates it into word-addressed `data_mem` port activity: word address, `wr_strb` encoding, and write-data lane placement. For loads it extracts and sign- or zero-extends the result. A small beat sequencer handles accesses that `data_mem` cannot perform in a single write or read.

## Interface
- `DEPTH`, 128: words in the attached `data_mem`; word address width is `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst=0` resets on the next rising edge).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`; request was rejected.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `mem_rd_addr`  out  AW  to `data_mem` `rd_addr0`.
- `mem_rd_data`  in  32  from `rd_dout0` (asynchronous read).
- `mem_wr_addr`  out  AW  to `wr_addr0`.
- `mem_wr_din`  out  32  to `wr_din0`.
- `mem_we`  out  1  to `we0`.
- `mem_wr_strb`  out  3  to `wr_strb`.

## Operation
- States: IDLE, BEAT, DONE.
  - `req_ready = 1` only in IDLE.
  - Handshake occurs when `req_valid & req_ready`. The controller registers `we`, `funct3`, `addr`, `wdata` and computes the beat count `n`.
- Error check at handshake:
  - funct3 ∈ {011, 110, 111} for a load, or any funct3[2]=1 for a store.
  - Any touched word index ≥ DEPTH.
  - Misaligned access with `LSU_MISALIGNED_EN` undefined.
  - On error: go to DONE with `n=0`, no memory activity.
- Aligned access: `n=1`.
  - Store `mem_wr_strb` values:
    - SW → 000.
    - SH at offset 0 → 001; SH at offset 2 → 011.
    - SB → {1, addr[1:0]}.
  - Store data is placed in `mem_wr_din[15:0]` or `[7:0]`, with upper bits = 0.
- Misaligned store: one byte beat per byte (SH → 2 beats, SW → 4), in ascending byte address order.
  - Each beat drives `mem_wr_strb = {1, byteaddr[1:0]}`, `mem_wr_addr = byteaddr[AW+1:2]`, and the byte in `mem_wr_din[7:0]`.
- Misaligned load: `n=2`. Beat 0 reads word A, beat 1 reads word A+1. The result is assembled little-endian.
- BEAT: memory outputs are driven from registered state.
  - `mem_we = req_we` in every beat.
  - The beat counter increments each cycle. On the last beat, go to DONE.
  - Load data is captured from `mem_rd_data` at the end of each read beat.
- DONE: `resp_valid = 1`, outputs registered, then return to IDLE.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Outside BEAT: `mem_we = 0`, and `mem_wr_strb = 010` (NOP).

## Timing
- C0 = handshake cycle.
- Beats occupy C1..Cn. `resp_valid` is high in cycle Cn+1, and `req_ready` is 1 in that cycle only after returning to IDLE (C(n+2)).
- Latencies from handshake to response:
  - Aligned load or store: response at C2; 3-cycle throughput.
  - Misaligned SW: response at C5.
  - Error: response at C1 with `resp_err = 1`.
- Memory writes commit at the rising edge ending each BEAT cycle.
- Reset values: `req_ready=0` during the reset cycle, then 1; `resp_valid=0`, `resp_err=0`, `resp_rdata=0`; `mem_we=0`, `mem_wr_strb=010`; `mem_rd_addr=0`, `mem_wr_addr=0`, `mem_wr_din=0`.
- Reset mid-operation: abort immediately, return to IDLE, and produce no response. Bytes already written remain written (no rollback).
- `req_*` inputs are ignored outside the handshake cycle.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned halfword/word accesses are split into beats as above.
- `LSU_MISALIGNED_EN` undefined: any misaligned LH/LHU/LW/SH/SW returns `resp_err=1` at C1 with no memory write. The beat counter is reduced to 1 bit.

## Test plan
- SW addr 0x8, wdata 0xDEADBEEF; then LW 0x8 → store beat `mem_wr_addr=2`, `mem_wr_strb=000`; load `resp_rdata=0xDEADBEEF` at C2.
- SB 0x0000_0080 at addr 0x5; then LB 0x5 → `mem_wr_strb=101`; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- With EN: SW 0x11223344 at addr 0x6 → 4 byte beats with strobes 110, 111, 100, 101 and word addrs 1, 1, 2, 2; LW 0x6 returns 0x11223344 at C3.
- Without EN: LH at addr 0x3 → `resp_err=1` at C1, `mem_we` never asserted.
- Load funct3=011, and SW at addr 4·DEPTH → both `resp_err=1`, `resp_rdata=0`.
- Reset asserted in beat 2 of a misaligned SW → next cycle IDLE, no `resp_valid`, only the first byte written.
